// File: rtl/w_mem_port_arbiter.sv
// w_mem_port_arbiter
// Shares the single-port weight memory between the DMA write requester and the
// MAC-array read requester. Writes win by default; a read that has watched
// MAX_WR_BURST consecutive writes go by is forced through. The memory's fixed
// one-cycle read latency is turned into a valid/ready response stream through
// a small response FIFO that only accepts reads it is guaranteed to hold.
module w_mem_port_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int ROW_BYTES    = 4,
    parameter int RSP_DEPTH    = 3,
    parameter int MAX_WR_BURST = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [ADDR_W-1:0]             wr_req_addr,
    input  logic [ROW_BYTES*DATA_W-1:0]   wr_req_data,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [ADDR_W-1:0]             rd_req_addr,
    output logic                          rd_rsp_valid,
    input  logic                          rd_rsp_ready,
    output logic [ROW_BYTES*DATA_W-1:0]   rd_rsp_data,
    output logic                          mem_wr_enable,
    output logic                          mem_rd_enable,
    output logic [ADDR_W-1:0]             mem_wr_addr,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    output logic [ROW_BYTES*DATA_W-1:0]   mem_wr_data,
    input  logic [ROW_BYTES*DATA_W-1:0]   mem_rd_data,
    output logic                          busy
);

    localparam int ROW_W = ROW_BYTES * DATA_W;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [7:0]       BURST_MAX = 8'(MAX_WR_BURST);

    // Registered state
    logic [7:0]       wr_streak_q, wr_streak_d;
    logic             inflight_q,  inflight_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;

    // Response storage (data only, no reset: visibility is gated by count)
    logic [ROW_W-1:0] fifo_mem [RSP_DEPTH];

    // Combinational control
    logic           space;
    logic           force_rd;
    logic           wr_grant;
    logic           rd_grant;
    logic           push;
    logic           pop;
    logic [CNT_W:0] occupancy;

    // Arbitration: occupancy counts both stored responses and the read already
    // on its way back, so an accepted read always has a slot waiting for it.
    always_comb begin
        occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        space     = (occupancy < DEPTH_OCC);
        force_rd  = rd_req_valid & space & (wr_streak_q == BURST_MAX);
        wr_grant  = wr_req_valid & ~force_rd;
        rd_grant  = rd_req_valid & ~wr_grant & space & ~clear;
    end

    // Memory-side drive and requester handshakes; idle buses are held at zero
    always_comb begin
        wr_req_ready  = wr_grant;
        rd_req_ready  = rd_grant;
        mem_wr_enable = wr_grant;
        mem_rd_enable = rd_grant;
        mem_wr_addr   = wr_grant ? wr_req_addr : '0;
        mem_wr_data   = wr_grant ? wr_req_data : '0;
        mem_rd_addr   = rd_grant ? rd_req_addr : '0;
    end

    // Response side: head of the FIFO, and the busy indication
    always_comb begin
        rd_rsp_valid = (count_q != '0);
        rd_rsp_data  = rd_rsp_valid ? fifo_mem[rd_ptr_q] : '0;
        busy         = inflight_q | rd_rsp_valid;
        push         = inflight_q & ~clear;
        pop          = rd_rsp_valid & rd_rsp_ready;
    end

    // Next-state computation for streak, in-flight flag and FIFO bookkeeping
    always_comb begin
        wr_streak_d = wr_streak_q;
        inflight_d  = rd_grant;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        // Streak only grows while a read is actually waiting
        if (rd_grant || !rd_req_valid) begin
            wr_streak_d = '0;
        end else if (wr_grant && (wr_streak_q != BURST_MAX)) begin
            wr_streak_d = wr_streak_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Flush drops stored data and the returning read; a write still goes
        if (clear) begin
            wr_streak_d = '0;
            inflight_d  = 1'b0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_streak_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            wr_streak_q <= wr_streak_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Capture returning read data into the slot addressed by the write pointer
    for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                fifo_mem[gi] <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_w_mem_port_arbiter.sv
// tb_w_mem_port_arbiter
// Drives directed scenarios followed by randomized traffic and compares every
// cycle against a queue-based model of the arbiter built from its rules.
module tb_w_mem_port_arbiter;

    localparam int ADDR_W       = 13;
    localparam int DATA_W       = 8;
    localparam int ROW_BYTES    = 4;
    localparam int RSP_DEPTH    = 3;
    localparam int MAX_WR_BURST = 8;
    localparam int RW           = ROW_BYTES * DATA_W;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [RW-1:0]     wr_req_data;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [RW-1:0]     rd_rsp_data;
    logic              mem_wr_enable;
    logic              mem_rd_enable;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [RW-1:0]     mem_wr_data;
    logic [RW-1:0]     mem_rd_data;
    logic              busy;

    w_mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .ROW_BYTES    (ROW_BYTES),
        .RSP_DEPTH    (RSP_DEPTH),
        .MAX_WR_BURST (MAX_WR_BURST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_ready  (rd_rsp_ready),
        .rd_rsp_data   (rd_rsp_data),
        .mem_wr_enable (mem_wr_enable),
        .mem_rd_enable (mem_rd_enable),
        .mem_wr_addr   (mem_wr_addr),
        .mem_rd_addr   (mem_rd_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_data   (mem_rd_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the weight memory as a pure function of the address
    function automatic logic [RW-1:0] row_of(input logic [ADDR_W-1:0] a);
        logic [RW-1:0] x;
        x = RW'(a);
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ x;
    endfunction

    // Memory: one-cycle read latency, garbage on the bus otherwise
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_enable ? row_of(mem_rd_addr) : RW'($urandom);
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: every accepted-but-not-popped read, oldest first
    logic [RW-1:0] exp_q[$];
    bit            inflight_m;
    int            streak_m;
    bit            last_wg;
    bit            last_rg;
    bit            last_pop;

    task automatic model_reset();
        exp_q.delete();
        inflight_m = 1'b0;
        streak_m   = 0;
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic do_cycle(input bit wv, input logic [ADDR_W-1:0] wa, input logic [RW-1:0] wd,
                            input bit rv, input logic [ADDR_W-1:0] ra, input bit rr, input bit cl);
        int            occ;
        bit            space;
        bit            frc;
        bit            wg;
        bit            rg;
        bit            vexp;
        logic [RW-1:0] dexp;
        @(negedge clk);
        wr_req_valid = wv;
        wr_req_addr  = wa;
        wr_req_data  = wd;
        rd_req_valid = rv;
        rd_req_addr  = ra;
        rd_rsp_ready = rr;
        clear        = cl;
        #1;
        occ   = exp_q.size();
        space = occ < RSP_DEPTH;
        frc   = rv && space && (streak_m == MAX_WR_BURST);
        wg    = wv && !frc;
        rg    = rv && !wg && space && !cl;
        vexp  = (occ - int'(inflight_m)) > 0;
        dexp  = vexp ? exp_q[0] : '0;

        check_eq("wr_req_ready", wr_req_ready, wg);
        check_eq("rd_req_ready", rd_req_ready, rg);
        check_eq("mem_wr_enable", mem_wr_enable, wg);
        check_eq("mem_rd_enable", mem_rd_enable, rg);
        check_eq("mem_wr_addr", mem_wr_addr, wg ? wa : '0);
        check_eq("mem_wr_data", mem_wr_data, wg ? wd : '0);
        check_eq("mem_rd_addr", mem_rd_addr, rg ? ra : '0);
        check_eq("both_enables", mem_wr_enable & mem_rd_enable, 1'b0);
        check_eq("rd_rsp_valid", rd_rsp_valid, vexp);
        check_eq("rd_rsp_data", rd_rsp_data, dexp);
        check_eq("busy", busy, occ > 0);
        check_eq("no_overflow", int'(dut.count_q) <= RSP_DEPTH, 1'b1);

        last_wg  = wg;
        last_rg  = rg;
        last_pop = vexp && rr;

        if (cl) begin
            model_reset();
        end else begin
            if (vexp && rr) begin
                $display("[TB] rsp %08h", exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (rg) exp_q.push_back(row_of(ra));
            inflight_m = rg;
            if (rg || !rv) streak_m = 0;
            else if (wg && streak_m < MAX_WR_BURST) streak_m++;
        end
    endtask

    // Asynchronous reset in the middle of a cycle with requests idle
    task automatic async_reset();
        @(negedge clk);
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        rd_rsp_ready = 1'b0;
        clear        = 1'b0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        rd_req_addr  = '0;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_rsp_valid", rd_rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rd_rsp_data, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_en", {mem_wr_enable, mem_rd_enable, wr_req_ready, rd_req_ready}, 4'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
    endtask

    int n_rd;
    int n_pop;

    initial begin
        reset        = 1'b0;
        clear        = 1'b0;
        wr_req_valid = 1'b0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        rd_rsp_ready = 1'b0;
        model_reset();

        // Reset state
        #2;
        check_eq("reset_outputs",
                 {wr_req_ready, rd_req_ready, rd_rsp_valid, mem_wr_enable, mem_rd_enable, busy}, 6'b0);
        check_eq("reset_buses", {mem_wr_addr, mem_rd_addr, mem_wr_data, rd_rsp_data}, '0);
        @(negedge clk);
        #2 reset = 1'b1;

        // Write pass-through
        do_cycle(1, 13'h0A5, 32'h1122_3344, 0, '0, 0, 0);
        check_eq("wr_pass_grant", last_wg, 1'b1);

        // Single read latency
        do_cycle(0, '0, '0, 1, 13'h010, 1, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, '0, '0, 0, '0, 1, 0);

        // Conflict / starvation: 8 writes then 1 read, three times over
        n_rd = 0;
        for (int i = 0; i < 27; i++) begin
            do_cycle(1, 13'(i), $urandom, 1, 13'(100 + i), 1, 0);
            n_rd += int'(last_rg);
        end
        check_eq("starve_rd_cnt", n_rd, 3);
        for (int i = 0; i < 4; i++) do_cycle(0, '0, '0, 0, '0, 1, 0);

        // Backpressure: exactly RSP_DEPTH reads accepted, writes still go
        n_rd = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, '0, '0, 1, 13'(200 + i), 0, 0);
            n_rd += int'(last_rg);
        end
        check_eq("bp_rd_cnt", n_rd, RSP_DEPTH);
        do_cycle(1, 13'h1F0, 32'hCAFE_F00D, 1, 13'h0300, 0, 0);
        check_eq("bp_wr_granted", last_wg, 1'b1);
        for (int i = 0; i < 6; i++) do_cycle(0, '0, '0, 1, 13'(300 + i), 1, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, '0, '0, 0, '0, 1, 0);

        // Streaming throughput: 16 back-to-back accepts and responses
        n_rd  = 0;
        n_pop = 0;
        for (int i = 0; i < 18; i++) begin
            do_cycle(0, '0, '0, i < 16, 13'(400 + i), 1, 0);
            n_rd  += int'(last_rg);
            n_pop += int'(last_pop);
        end
        check_eq("stream_rd_cnt", n_rd, 16);
        check_eq("stream_pop_cnt", n_pop, 16);
        for (int i = 0; i < 2; i++) do_cycle(0, '0, '0, 0, '0, 1, 0);

        // clear with two stored responses plus one in flight
        for (int i = 0; i < 3; i++) do_cycle(0, '0, '0, 1, 13'(500 + i), 0, 0);
        do_cycle(1, 13'h0777, 32'h0BAD_BEEF, 0, '0, 0, 1);
        check_eq("clear_wr_granted", last_wg, 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(0, '0, '0, 0, '0, 1, 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) do_cycle(0, '0, '0, 1, 13'(600 + i), 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) do_cycle(0, '0, '0, 0, '0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) async_reset();
            do_cycle($urandom_range(0, 99) < 60, 13'($urandom), $urandom,
                     $urandom_range(0, 99) < 80, 13'($urandom),
                     $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
